// File: rtl/clk_pkg.sv
// Shared types for the PLL supervisor: FSM state encoding,
// relock counter width and its saturating increment.
package clk_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RESET,
        ST_WAIT_LOCK,
        ST_RELEASE,
        ST_RUN,
        ST_FAIL
    } sup_state_e;

    localparam int RELOCK_W = 8;

    function automatic logic [RELOCK_W-1:0] sat_inc(
        input logic [RELOCK_W-1:0] v
    );
        return (&v) ? v : v + RELOCK_W'(1);
    endfunction

endpackage

// File: rtl/rst_stagger.sv
// Staggered downstream reset release: counts cycles spent in RELEASE
// and frees one reset bit every RST_STAGGER_CYCLES, bit 0 first.
module rst_stagger
    import clk_pkg::*;
#(
    parameter int NUM_RST_OUT        = 2,
    parameter int RST_STAGGER_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  sup_state_e             state_q_i,
    input  sup_state_e             state_d_i,
    output logic                   done_o,
    output logic [NUM_RST_OUT-1:0] rst_out_o
);

    localparam int TOTAL = RST_STAGGER_CYCLES * NUM_RST_OUT;
    localparam int CW    = $clog2(TOTAL) + 1;

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_RST_OUT-1:0] rst_out_q, rst_out_d;

    // Counter is zero on the RELEASE entry cycle and tracks cycles since.
    always_comb begin
        cnt_d     = '0;
        rst_out_d = '1;
        if (state_q_i == ST_RELEASE && state_d_i == ST_RELEASE) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (state_d_i == ST_RUN) begin
            rst_out_d = '0;
        end else if (state_d_i == ST_RELEASE) begin
            for (int i = 0; i < NUM_RST_OUT; i++) begin
                rst_out_d[i] = (cnt_d < CW'(RST_STAGGER_CYCLES * (i + 1)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            rst_out_q <= '1;
        end else begin
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
        end
    end

    assign done_o    = (cnt_q >= CW'(TOTAL));
    assign rst_out_o = rst_out_q;

endmodule

// File: rtl/pll_supervisor.sv
// PLL bring-up supervisor: pulses PLL reset, qualifies lock, retries on
// timeout, releases downstream resets in a staggered order, tracks relocks.
module pll_supervisor
    import clk_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int NUM_RST_OUT         = 2,
    parameter int RST_STAGGER_CYCLES  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pll_lock_i,
    input  logic                   restart_i,
    output logic                   pll_rst_o,
    output logic [NUM_RST_OUT-1:0] rst_out_o,
    output logic                   ready_o,
    output logic                   fail_o,
    output logic [RELOCK_W-1:0]    relock_cnt_o
);

    localparam int RST_W = $clog2(PLL_RST_CYCLES) + 1;
    localparam int TMO_W = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
    localparam int CNT_W = (RST_W > TMO_W) ? RST_W : TMO_W;
    localparam int STB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int RTY_W = $clog2(MAX_RETRIES + 1) + 1;

    sup_state_e          state_q, state_d;
    logic                sync_q, lock_s_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STB_W-1:0]    stable_q, stable_d;
    logic [RTY_W-1:0]    retry_q, retry_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic                pll_rst_q, ready_q, fail_q;
    logic                rel_done;

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        stable_d = '0;
        cnt_d    = '0;
        unique case (state_q)
            ST_PLL_RESET: begin
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    stable_d = stable_q + STB_W'(1);
                end
                // Acceptance wins over a timeout landing on the same cycle.
                if (stable_d == STB_W'(LOCK_STABLE_CYCLES)) begin
                    state_d = ST_RELEASE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    retry_d = retry_q + RTY_W'(1);
                    state_d = (retry_d > RTY_W'(MAX_RETRIES)) ?
                              ST_FAIL : ST_PLL_RESET;
                end
            end
            ST_RELEASE: begin
                if (!lock_s_q) begin
                    state_d = ST_PLL_RESET;
                end else if (rel_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d  = ST_PLL_RESET;
                    relock_d = sat_inc(relock_q);
                    retry_d  = '0;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_PLL_RESET;
            end
        endcase
        if (restart_i) begin
            state_d  = ST_PLL_RESET;
            retry_d  = '0;
            relock_d = relock_q;
        end
        if (state_d != ST_WAIT_LOCK) begin
            stable_d = '0;
        end
        // Cycle counter runs only while timing PLL_RESET or WAIT_LOCK.
        if (!restart_i && state_d == state_q &&
            (state_q == ST_PLL_RESET || state_q == ST_WAIT_LOCK)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_PLL_RESET;
            sync_q    <= 1'b0;
            lock_s_q  <= 1'b0;
            cnt_q     <= '0;
            stable_q  <= '0;
            retry_q   <= '0;
            relock_q  <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= pll_lock_i;
            lock_s_q  <= sync_q;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            retry_q   <= retry_d;
            relock_q  <= relock_d;
            pll_rst_q <= (state_d == ST_PLL_RESET) || (state_d == ST_FAIL);
            ready_q   <= (state_d == ST_RUN);
            fail_q    <= (state_d == ST_FAIL);
        end
    end

    rst_stagger #(
        .NUM_RST_OUT        (NUM_RST_OUT),
        .RST_STAGGER_CYCLES (RST_STAGGER_CYCLES)
    ) u_rst_stagger (
        .clk       (clk),
        .rst       (rst),
        .state_q_i (state_q),
        .state_d_i (state_d),
        .done_o    (rel_done),
        .rst_out_o (rst_out_o)
    );

    assign pll_rst_o    = pll_rst_q;
    assign ready_o      = ready_q;
    assign fail_o       = fail_q;
    assign relock_cnt_o = relock_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor: per-cycle expected outputs are
// queued with each stimulus step and popped against the DUT after each edge.
module tb_pll_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock_i;
    logic       restart_i;
    logic       pll_rst_o;
    logic [1:0] rst_out_o;
    logic       ready_o;
    logic       fail_o;
    logic [7:0] relock_cnt_o;

    always #5 clk = ~clk;

    pll_supervisor #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (1),
        .NUM_RST_OUT         (2),
        .RST_STAGGER_CYCLES  (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_lock_i   (pll_lock_i),
        .restart_i    (restart_i),
        .pll_rst_o    (pll_rst_o),
        .rst_out_o    (rst_out_o),
        .ready_o      (ready_o),
        .fail_o       (fail_o),
        .relock_cnt_o (relock_cnt_o)
    );

    typedef struct {
        string      tag;
        logic       pr;
        logic [1:0] ro;
        logic       rdy;
        logic       fl;
        logic [7:0] rc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   npass = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input string tag, input logic pr,
                          input logic [1:0] ro, input logic rdy,
                          input logic fl, input logic [7:0] rc);
        exp_t e;
        e.tag = tag;
        e.pr  = pr;
        e.ro  = ro;
        e.rdy = rdy;
        e.fl  = fl;
        e.rc  = rc;
        repeat (n) sb.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [12:0] obs;
        logic [12:0] want;
        total++;
        if (sb.size() == 0) begin
            $error("FAIL sb_empty: observed no queued expectation, required one");
            return;
        end
        e    = sb.pop_front();
        obs  = {pll_rst_o, rst_out_o, ready_o, fail_o, relock_cnt_o};
        want = {e.pr, e.ro, e.rdy, e.fl, e.rc};
        assert (obs === want) npass++;
        else $error("FAIL %s: observed pll_rst=%b rst_out=%b ready=%b fail=%b relock=%0d, expected pll_rst=%b rst_out=%b ready=%b fail=%b relock=%0d",
                    e.tag, pll_rst_o, rst_out_o, ready_o, fail_o, relock_cnt_o,
                    e.pr, e.ro, e.rdy, e.fl, e.rc);
    endtask

    task automatic step_check(input int n);
        repeat (n) begin
            tick();
            check();
        end
    endtask

    initial begin
        rst        = 1'b1;
        pll_lock_i = 1'b0;
        restart_i  = 1'b0;
        repeat (3) tick();

        // Reset values.
        push_n(1, "reset", 1, 2'b11, 0, 0, 0);
        step_check(1);

        // Bring-up: 3 more PLL reset cycles after release, then WAIT_LOCK.
        rst = 1'b0;
        push_n(3, "boot_prst", 1, 2'b11, 0, 0, 0);
        push_n(1, "boot_fall", 0, 2'b11, 0, 0, 0);
        push_n(5, "boot_wait", 0, 2'b11, 0, 0, 0);
        step_check(9);

        // Lock rises: 2 sync + 8 stable -> RELEASE at +10; bits free at +13/+16.
        pll_lock_i = 1'b1;
        push_n(12, "lk_wait", 0, 2'b11, 0, 0, 0);
        push_n(3,  "lk_rel0", 0, 2'b10, 0, 0, 0);
        push_n(1,  "lk_rel1", 0, 2'b00, 0, 0, 0);
        push_n(3,  "lk_run",  0, 2'b00, 1, 0, 0);
        step_check(19);

        // One-cycle lock drop in RUN: seen 3 edges later, then full relock.
        pll_lock_i = 1'b0;
        push_n(2,  "drop_run",  0, 2'b00, 1, 0, 0);
        push_n(4,  "drop_prst", 1, 2'b11, 0, 0, 1);
        push_n(11, "drop_wait", 0, 2'b11, 0, 0, 1);
        push_n(3,  "drop_rel0", 0, 2'b10, 0, 0, 1);
        push_n(1,  "drop_rel1", 0, 2'b00, 0, 0, 1);
        push_n(3,  "drop_run2", 0, 2'b00, 1, 0, 1);
        tick();
        check();
        pll_lock_i = 1'b1;
        step_check(23);

        // Restart from RUN with lock low, then lock with a glitch at 6 cycles.
        restart_i  = 1'b1;
        pll_lock_i = 1'b0;
        push_n(4, "gl_prst", 1, 2'b11, 0, 0, 1);
        push_n(1, "gl_fall", 0, 2'b11, 0, 0, 1);
        tick();
        check();
        restart_i = 1'b0;
        step_check(4);
        push_n(19, "gl_wait", 0, 2'b11, 0, 0, 1);
        push_n(3,  "gl_rel0", 0, 2'b10, 0, 0, 1);
        push_n(1,  "gl_rel1", 0, 2'b00, 0, 0, 1);
        push_n(3,  "gl_run",  0, 2'b00, 1, 0, 1);
        pll_lock_i = 1'b1;
        step_check(6);
        pll_lock_i = 1'b0;
        step_check(1);
        pll_lock_i = 1'b1;
        step_check(19);

        // Restart with lock never rising: two timeouts, then FAIL.
        restart_i  = 1'b1;
        pll_lock_i = 1'b0;
        push_n(4,  "to_prst1", 1, 2'b11, 0, 0, 1);
        push_n(32, "to_wait1", 0, 2'b11, 0, 0, 1);
        push_n(4,  "to_prst2", 1, 2'b11, 0, 0, 1);
        push_n(32, "to_wait2", 0, 2'b11, 0, 0, 1);
        push_n(4,  "to_fail",  1, 2'b11, 0, 1, 1);
        tick();
        check();
        restart_i = 1'b0;
        step_check(75);

        // Restart out of FAIL with lock present: normal sequence, relock kept.
        restart_i  = 1'b1;
        pll_lock_i = 1'b1;
        push_n(4,  "rs_prst", 1, 2'b11, 0, 0, 1);
        push_n(11, "rs_wait", 0, 2'b11, 0, 0, 1);
        push_n(3,  "rs_rel0", 0, 2'b10, 0, 0, 1);
        push_n(1,  "rs_rel1", 0, 2'b00, 0, 0, 1);
        push_n(3,  "rs_run",  0, 2'b00, 1, 0, 1);
        tick();
        check();
        restart_i = 1'b0;
        step_check(21);

        // Restart again, then rst together with restart inside RELEASE.
        restart_i = 1'b1;
        push_n(4,  "rr_prst", 1, 2'b11, 0, 0, 1);
        push_n(10, "rr_pre",  0, 2'b11, 0, 0, 1);
        tick();
        check();
        restart_i = 1'b0;
        step_check(13);
        rst       = 1'b1;
        restart_i = 1'b1;
        push_n(1, "rr_rst", 1, 2'b11, 0, 0, 0);
        step_check(1);
        rst       = 1'b0;
        restart_i = 1'b0;
        push_n(1, "rr_post", 1, 2'b11, 0, 0, 0);
        step_check(1);

        total++;
        assert (sb.size() == 0) npass++;
        else $error("FAIL sb_drain: observed %0d leftover, expected 0", sb.size());

        $display("%0d/%0d checks passed", npass, total);
        $finish;
    end

endmodule

// File: doc/pll_supervisor.md
PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles pll_rst_o is held high per PLL reset attempt (>=1).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronised-lock-high cycles required before lock is accepted (>=1).
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: cycles allowed in WAIT_LOCK before the attempt is declared failed (>LOCK_STABLE_CYCLES).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: failed attempts tolerated before entering FAIL (>=0).
REQ-005 SHALL have parameter NUM_RST_OUT, default 2: number of downstream reset outputs (1..8).
REQ-006 SHALL have parameter RST_STAGGER_CYCLES, default 8: gap in cycles between successive downstream reset releases (>=1).
REQ-007 clk  input  1  free-running reference clock (PLL input clock domain).
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 pll_lock_i  input  1  raw PLL LOCK, asynchronous to clk.
REQ-010 restart_i  input  1  single-cycle request to restart the whole sequence.
REQ-011 pll_rst_o  output  1  PLL RESET drive, active-high.
REQ-012 rst_out_o  output  NUM_RST_OUT  downstream synchronous resets, active-high, bit 0 released first.
REQ-013 ready_o  output  1  high only in RUN.
REQ-014 fail_o  output  1  high only in FAIL.
REQ-015 relock_cnt_o  output  8  loss-of-lock events seen in RUN, saturating at 255.

Function
REQ-016 pll_lock_i SHALL pass a 2-flop synchroniser; all logic uses the synchronised lock_s only.
REQ-017 FSM states: PLL_RESET, WAIT_LOCK, RELEASE, RUN, FAIL.
REQ-018 PLL_RESET: pll_rst_o=1 for exactly PLL_RST_CYCLES cycles, then -> WAIT_LOCK with pll_rst_o=0.
REQ-019 WAIT_LOCK: stable counter increments while lock_s=1, clears to 0 on any lock_s=0 cycle; reaching LOCK_STABLE_CYCLES -> RELEASE.
REQ-020 WAIT_LOCK: timeout counter reaching LOCK_TIMEOUT_CYCLES without acceptance -> retry counter +1; if retries then exceed MAX_RETRIES -> FAIL, else -> PLL_RESET.
REQ-021 RELEASE: rst_out_o[i] SHALL deassert RST_STAGGER_CYCLES*(i+1) cycles after RELEASE entry; after the last bit deasserts -> RUN next cycle.
REQ-022 RUN: ready_o=1; lock_s=0 for one cycle -> assert all rst_out_o same cycle as transition, relock_cnt_o +1 (saturating), retry counter cleared, -> PLL_RESET.
REQ-023 RELEASE: lock_s=0 -> all rst_out_o reasserted, -> PLL_RESET, retry counter unchanged, relock_cnt_o unchanged.
REQ-024 FAIL: pll_rst_o=1, all rst_out_o=1, fail_o=1; left only by restart_i or rst.
REQ-025 restart_i in any state SHALL: clear retry counter, assert all rst_out_o, -> PLL_RESET next cycle; relock_cnt_o preserved.
REQ-026 rst_out_o SHALL be 1 in every state except RELEASE (per staggered schedule) and RUN.
REQ-027 All outputs SHALL be registered; no combinational path from pll_lock_i or restart_i to any output.
REQ-028 Counter widths SHALL be $clog2 of their parameter +1; no wrap-around permitted before terminal compare.

Reset
REQ-029 rst SHALL set: state=PLL_RESET, pll_rst_o=1, rst_out_o=all ones, ready_o=0, fail_o=0, relock_cnt_o=0, all counters and synchroniser flops 0.
REQ-030 rst asserted mid-sequence SHALL take priority over restart_i and all FSM transitions in that cycle.

Structure
REQ-031 State enum and relock counter width (8) SHALL live in shared package clk_pkg.
REQ-032 The staggered release SHALL be one sub-module, rst_stagger, instantiated once, containing the release counter and rst_out_o registers.

Verification (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=1, NUM_RST_OUT=2, RST_STAGGER_CYCLES=3)
REQ-033 Lock rises 5 cycles after pll_rst_o falls, held -> rst_out_o[0] low 3 cycles after RELEASE entry, [1] low at 6, ready_o high at 7.
REQ-034 Lock glitches low once after 6 high cycles -> stable counter restarts; RELEASE entered only after 8 further consecutive high cycles.
REQ-035 Lock never rises -> two 32-cycle timeouts, each preceded by 4-cycle pll_rst_o pulse, then fail_o=1, pll_rst_o=1.
REQ-036 In RUN, lock drops 1 cycle -> rst_out_o=2'b11 and ready_o=0 next cycle, relock_cnt_o=1, full sequence repeats.
REQ-037 restart_i pulse in FAIL -> fail_o=0 next cycle, 4-cycle pll_rst_o, normal lock sequence completes with relock_cnt_o unchanged.
REQ-038 rst asserted during RELEASE with restart_i same cycle -> all outputs equal REQ-029 values next cycle.
